mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle control FSM that sequences the shared MIPS datapath: PC, one unified memory port, IR, register file, a single ALU and ALUOut.
- Consumes opcode/funcode from the instruction-field decoder and the ALU zero flag; drives every datapath mux/enable, one step per clock.
- Memory accesses use a ready handshake with a timeout-and-retry mechanism.

Parameters:
- MEM_WAIT_MAX, 15, max cycles to wait for mem_ready in any memory state before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], stable from the cycle after ir_write
- funcode  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational
- mem_ready  in  1  memory completes current access this cycle
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
- i_or_d  out  1  0 = address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_write  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_ctrl  out  4  ALU operation code
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse at the last cycle of each completed instruction
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode/funct
- mem_err  out  1  one-cycle pulse on memory timeout
- state  out  4  current state, debug

Behaviour:
- States (4-bit): RST=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, BRANCH=9, JUMP=10, I_EXEC=11, I_WB=12.
- rst at any cycle (including mid-instruction): next state RST, wait counter = 0.
- In RST all outputs are 0; state=0.
- RST -> FETCH unconditionally.
- Default value of every output is 0 unless listed for the state.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_source=00.
  - ir_write = pc_en = mem_ready.
  - On mem_ready -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct in {0x20,0x21,0x22,0x23,0x24,0x25,0x2A} -> R_EXEC.
  - 0x23 (lw) and 0x2B (sw) -> MEM_ADDR.
  - 0x04 (beq) -> BRANCH.
  - 0x02 (j) -> JUMP.
  - 0x09 (addiu), 0x0D (ori), 0x0A (slti) -> I_EXEC.
  - Anything else: illegal=1 -> FETCH. No retire; PC has already advanced by 4.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready: retire=1 -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - 0x20/0x21 -> ADD
  - 0x22/0x23 -> SUB
  - 0x24 -> AND
  - 0x25 -> OR
  - 0x2A -> SLT
  - Next -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write_cond=1 (so pc_en=zero), retire=1 -> FETCH.
- JUMP: pc_source=10, pc_en=1, retire=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10; addiu -> ADD, ori -> OR, slti -> SLT. Next -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1 -> FETCH.
- Opcode is latched into an internal register in DECODE. Later states use the latched copy; funct is also latched.
- Wait counter (8-bit):
  - Cleared on entry to FETCH/MEM_RD/MEM_WR and whenever mem_ready=1.
  - Increments each waiting cycle.
  - Reaching MEM_WAIT_MAX without mem_ready: mem_err=1, outputs of that cycle suppressed (no ir_write/pc_en/writes), next state FETCH.
  - A fetch timeout therefore retries the same PC. A load/store timeout abandons the instruction: no retire.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_ready on the same cycle the counter hits MEM_WAIT_MAX: ready wins, no mem_err.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU, OP_ORI, OP_SLTI)
  - funct constants
  - ALU codes: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111
  - ALU_SRC_B and PC_SRC encodings
- One natural sub-module: mc_alu_dec (combinational funct -> alu_ctrl), reused by the ALU team.

Test Plan:
- rst=1 for 2 cycles mid-MEM_RD -> state=0 with all outputs 0; one cycle later state=1, mem_read=1.
- addu (op 0, funct 0x21) with mem_ready=1 in FETCH -> states 1,2,7,8,1; reg_dst=1 and reg_write=1 in state 8; retire pulses once; alu_ctrl=0010 in state 7.
- lw with mem_ready delayed 3 cycles in MEM_RD -> stays in state 4 for 4 cycles with i_or_d=1, then 5 with mem_to_reg=1; instruction takes 8 cycles total.
- beq with zero=1 -> pc_en=1 and pc_source=01 in state 9; with zero=0 -> pc_en=0; both retire.
- Opcode 0x3F -> illegal pulse in DECODE, back to FETCH, no retire.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> mem_err after 15 waiting cycles, ir_write never asserted, state re-enters FETCH; mem_ready on exactly the 15th cycle -> no mem_err, DECODE follows.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes, functs,
// ALU operation codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        StRst     = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StRExec   = 4'd7,
        StRWb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StIExec   = 4'd11,
        StIWb     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT};
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct to ALU operation decoder; unknown functs fall back to ADD.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (funct_i)
            FN_ADD, FN_ADDU: alu_ctrl_o = ALU_ADD;
            FN_SUB, FN_SUBU: alu_ctrl_o = ALU_SUB;
            FN_AND:          alu_ctrl_o = ALU_AND;
            FN_OR:           alu_ctrl_o = ALU_OR;
            FN_SLT:          alu_ctrl_o = ALU_SLT;
            default:         alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences the shared datapath one step per clock,
// with a bounded wait on every memory access.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    // Counter value seen on the last permitted waiting cycle.
    localparam logic [7:0] WaitLast = 8'(MEM_WAIT_MAX - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic [3:0] r_alu_ctrl;
    logic       pc_write, pc_write_cond;
    logic       timeout;

    mc_alu_dec u_alu_dec (
        .funct_i    (fn_q),
        .alu_ctrl_o (r_alu_ctrl)
    );

    assign timeout = !mem_ready && (wait_q == WaitLast);
    assign pc_en   = pc_write | (pc_write_cond & zero);
    assign state   = state_q;

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        op_d          = op_q;
        fn_d          = fn_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_ctrl      = ALU_AND;
        pc_source     = PC_SRC_ALU;
        retire        = 1'b0;
        illegal       = 1'b0;
        mem_err       = 1'b0;

        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    mem_err = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                // Speculative branch target lands in ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                alu_ctrl  = ALU_ADD;
                op_d      = opcode;
                fn_d      = funcode;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_legal(funcode)) begin
                            state_d = StRExec;
                        end else begin
                            illegal = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    OP_LW, OP_SW:               state_d = StMemAddr;
                    OP_BEQ:                     state_d = StBranch;
                    OP_J:                       state_d = StJump;
                    OP_ADDIU, OP_ORI, OP_SLTI:  state_d = StIExec;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                state_d   = (op_q == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = StFetch;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                i_or_d    = 1'b1;
                mem_write = !timeout;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = StFetch;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_ctrl  = r_alu_ctrl;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_ctrl      = ALU_SUB;
                pc_source     = PC_SRC_ALUOUT;
                pc_write_cond = 1'b1;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_source = PC_SRC_JUMP;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (op_q)
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRst;
            wait_q  <= '0;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus a randomized instruction
// stream checked against a per-instruction cycle-trace model.
module tb_mc_control;

    localparam int MAXW = 15;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] opcode, funcode;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, retire, illegal, mem_err;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_ctrl, state;
    logic [19:0] outs_w;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] st;
        logic       rdy, z;
        logic       ret, ill, merr, pcen, rw, irw, mw, mrd;
        logic       chk_alu;
        logic [3:0] alu;
    } cyc_t;

    cyc_t exp_q[$];

    logic [5:0] legal_ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h09, 6'h0D, 6'h0A};
    logic [5:0] legal_fns [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};

    mc_control #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funcode    (funcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .pc_source  (pc_source),
        .retire     (retire),
        .illegal    (illegal),
        .mem_err    (mem_err),
        .state      (state)
    );

    assign outs_w = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, alu_ctrl, pc_source, retire, illegal, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] ref_alu_r(input logic [5:0] f);
        if (f == 6'h20 || f == 6'h21) return 4'b0010;
        if (f == 6'h22 || f == 6'h23) return 4'b0110;
        if (f == 6'h24) return 4'b0000;
        if (f == 6'h25) return 4'b0001;
        return 4'b0111;
    endfunction

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c = '{default: '0};
        c.st  = st;
        c.rdy = ($urandom_range(0, 1) == 1);
        c.z   = ($urandom_range(0, 1) == 1);
        return c;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from the first FETCH cycle on.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input int fd,
                               input int md, input logic zb);
        cyc_t c;
        int d;
        bit legal, is_sw;
        exp_q.delete();
        d = fd;
        while (d >= MAXW) begin
            for (int i = 0; i < MAXW; i++) begin
                c = blank(4'd1); c.rdy = 0; c.mrd = 1; c.merr = (i == MAXW - 1);
                exp_q.push_back(c);
            end
            d -= MAXW;
        end
        for (int i = 0; i < d; i++) begin
            c = blank(4'd1); c.rdy = 0; c.mrd = 1; exp_q.push_back(c);
        end
        c = blank(4'd1); c.rdy = 1; c.mrd = 1; c.irw = 1; c.pcen = 1; exp_q.push_back(c);
        legal = 0;
        foreach (legal_ops[i]) if (legal_ops[i] == op && op != 6'h00) legal = 1;
        if (op == 6'h00) foreach (legal_fns[i]) if (legal_fns[i] == fn) legal = 1;
        c = blank(4'd2); c.ill = !legal; exp_q.push_back(c);
        if (!legal) return;
        case (op)
            6'h00: begin
                c = blank(4'd7); c.chk_alu = 1; c.alu = ref_alu_r(fn); exp_q.push_back(c);
                c = blank(4'd8); c.rw = 1; c.ret = 1; exp_q.push_back(c);
            end
            6'h23, 6'h2B: begin
                is_sw = (op == 6'h2B);
                c = blank(4'd3); exp_q.push_back(c);
                if (md >= MAXW) begin
                    for (int i = 0; i < MAXW; i++) begin
                        c = blank(is_sw ? 4'd6 : 4'd4); c.rdy = 0;
                        c.merr = (i == MAXW - 1);
                        c.mrd = !is_sw; c.mw = is_sw && !c.merr;
                        exp_q.push_back(c);
                    end
                    return;
                end
                for (int i = 0; i <= md; i++) begin
                    c = blank(is_sw ? 4'd6 : 4'd4); c.rdy = (i == md);
                    c.mrd = !is_sw; c.mw = is_sw; c.ret = is_sw && (i == md);
                    exp_q.push_back(c);
                end
                if (!is_sw) begin
                    c = blank(4'd5); c.rw = 1; c.ret = 1; exp_q.push_back(c);
                end
            end
            6'h04: begin
                c = blank(4'd9); c.z = zb; c.pcen = zb; c.ret = 1;
                c.chk_alu = 1; c.alu = 4'b0110; exp_q.push_back(c);
            end
            6'h02: begin
                c = blank(4'd10); c.pcen = 1; c.ret = 1; exp_q.push_back(c);
            end
            default: begin
                c = blank(4'd11); c.chk_alu = 1;
                c.alu = (op == 6'h0D) ? 4'b0001 : (op == 6'h0A) ? 4'b0111 : 4'b0010;
                exp_q.push_back(c);
                c = blank(4'd12); c.rw = 1; c.ret = 1; exp_q.push_back(c);
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1; mem_ready = 0; zero = 0; opcode = 6'h00; funcode = 6'h00;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({state, outs_w} !== 24'h0) begin
            n_fail++; $display("FAIL reset_por: got %h, want 0", {state, outs_w});
        end
        rst = 0;
        @(negedge clk); #1;
        n_tests++;
        if (state !== 4'd1 || mem_read !== 1'b1) begin
            n_fail++; $display("FAIL reset_exit: state %0d mem_read %b, want 1/1", state, mem_read);
        end
        opcode = 6'h23; mem_ready = 1;
        @(negedge clk); mem_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (state !== 4'd4) begin
            n_fail++; $display("FAIL reset_reach_memrd: state %0d, want 4", state);
        end
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({state, outs_w} !== 24'h0) begin
            n_fail++; $display("FAIL reset_mid_memrd: got %h, want 0", {state, outs_w});
        end
        rst = 0;
        @(negedge clk); #1;
        n_tests++;
        if (state !== 4'd1 || mem_read !== 1'b1) begin
            n_fail++; $display("FAIL reset_refetch: state %0d mem_read %b, want 1/1", state, mem_read);
        end
    endtask

    task automatic test_addu();
        logic [3:0] exp_st [4] = '{4'd1, 4'd2, 4'd7, 4'd8};
        int rets = 0;
        opcode = 6'h00; funcode = 6'h21;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0); zero = ($urandom_range(0, 1) == 1);
            #1;
            n_tests++;
            if (state !== exp_st[i]) begin
                n_fail++; $display("FAIL addu_state[%0d]: got %0d, want %0d", i, state, exp_st[i]);
            end
            rets += int'(retire);
            if (i == 2) begin
                n_tests++;
                if ({alu_ctrl, alu_src_a, alu_src_b} !== 7'b0010_1_00) begin
                    n_fail++;
                    $display("FAIL addu_exec: alu %b a %b b %b, want 0010/1/00",
                             alu_ctrl, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                n_tests++;
                if ({reg_dst, reg_write, mem_to_reg} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL addu_wb: dst %b wr %b m2r %b, want 1/1/0",
                             reg_dst, reg_write, mem_to_reg);
                end
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (state !== 4'd1 || rets != 1) begin
            n_fail++; $display("FAIL addu_end: state %0d retires %0d, want 1/1", state, rets);
        end
    endtask

    task automatic test_lw_delay();
        logic [3:0] exp_st [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
        logic       rdy    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 6'h23; funcode = 6'h00;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            n_tests++;
            if (state !== exp_st[i]) begin
                n_fail++; $display("FAIL lw_state[%0d]: got %0d, want %0d", i, state, exp_st[i]);
            end
            if (exp_st[i] == 4'd4) begin
                n_tests++;
                if ({i_or_d, mem_read, mem_err} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL lw_memrd[%0d]: iord %b rd %b err %b, want 1/1/0",
                             i, i_or_d, mem_read, mem_err);
                end
            end
            if (i == 7) begin
                n_tests++;
                if ({mem_to_reg, reg_write, reg_dst, retire} !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL lw_wb: m2r %b wr %b dst %b ret %b, want 1/1/0/1",
                             mem_to_reg, reg_write, reg_dst, retire);
                end
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL lw_end: state %0d, want 1", state);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'h04; funcode = 6'($urandom_range(0, 63));
            mem_ready = 1; #1; @(negedge clk);
            mem_ready = 0; #1; @(negedge clk);
            zero = (z == 1);
            #1;
            n_tests++;
            if ({state, pc_en, pc_source, retire, alu_ctrl} !== {4'd9, zero, 2'b01, 1'b1, 4'b0110}) begin
                n_fail++;
                $display("FAIL beq_z%0d: st %0d pc_en %b src %b ret %b alu %b, want 9/%0d/01/1/0110",
                         z, state, pc_en, pc_source, retire, alu_ctrl, z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'h3F; funcode = 6'h20;
        mem_ready = 1; #1; @(negedge clk);
        mem_ready = 1; #1;
        n_tests++;
        if ({state, illegal, retire} !== {4'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_decode: st %0d ill %b ret %b, want 2/1/0", state, illegal, retire);
        end
        @(negedge clk); mem_ready = 0; #1;
        n_tests++;
        if ({state, illegal, retire} !== {4'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_next: st %0d ill %b ret %b, want 1/0/0", state, illegal, retire);
        end
    endtask

    task automatic test_fetch_timeout();
        opcode = 6'h02;
        for (int i = 0; i < MAXW; i++) begin
            mem_ready = 0; #1;
            n_tests++;
            if ({state, mem_err, ir_write, pc_en} !== {4'd1, (i == MAXW - 1), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_timeout[%0d]: st %0d err %b irw %b pc_en %b", i, state,
                         mem_err, ir_write, pc_en);
            end
            @(negedge clk);
        end
        for (int i = 0; i < MAXW; i++) begin
            mem_ready = (i == MAXW - 1); #1;
            n_tests++;
            if ({state, mem_err, ir_write} !== {4'd1, 1'b0, (i == MAXW - 1)}) begin
                n_fail++;
                $display("FAIL fetch_ready_at_limit[%0d]: st %0d err %b irw %b", i, state,
                         mem_err, ir_write);
            end
            @(negedge clk);
        end
        mem_ready = 0; #1;
        n_tests++;
        if (state !== 4'd2) begin
            n_fail++; $display("FAIL fetch_limit_decode: state %0d, want 2", state);
        end
        @(negedge clk); #1;
        n_tests++;
        if ({state, pc_en, pc_source, retire} !== {4'd10, 1'b1, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL jump: st %0d pc_en %b src %b ret %b, want 10/1/10/1",
                     state, pc_en, pc_source, retire);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        int k, fd, md;
        logic zb;
        logic [11:0] ev, av, mask;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            if (k < 8) op = legal_ops[k];
            else if (k == 8) op = 6'($urandom_range(0, 63));
            else op = 6'h00;
            fn = (k == 9) ? 6'($urandom_range(0, 63)) : legal_fns[$urandom_range(0, 6)];
            fd = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXW, MAXW + 5) : $urandom_range(0, 3);
            md = ($urandom_range(0, 5) == 0) ? $urandom_range(MAXW, MAXW + 3) : $urandom_range(0, 4);
            zb = ($urandom_range(0, 1) == 1);
            opcode = op; funcode = fn;
            model_instr(op, fn, fd, md, zb);
            foreach (exp_q[j]) begin
                mem_ready = exp_q[j].rdy; zero = exp_q[j].z;
                #1;
                ev = {exp_q[j].st, exp_q[j].ret, exp_q[j].ill, exp_q[j].merr, exp_q[j].pcen,
                      exp_q[j].rw, exp_q[j].irw, exp_q[j].mw, exp_q[j].mrd};
                av = {state, retire, illegal, mem_err, pc_en, reg_write, ir_write, mem_write,
                      mem_read};
                mask = exp_q[j].merr ? 12'hFFE : 12'hFFF;
                n_tests++;
                if ((av & mask) !== (ev & mask)) begin
                    n_fail++;
                    $display("FAIL rand[%0d.%0d] op %h fn %h: got %b, want %b", n, j, op, fn,
                             av & mask, ev & mask);
                end
                if (exp_q[j].chk_alu) begin
                    n_tests++;
                    if (alu_ctrl !== exp_q[j].alu) begin
                        n_fail++;
                        $display("FAIL rand_alu[%0d] op %h fn %h: got %b, want %b", n, op, fn,
                                 alu_ctrl, exp_q[j].alu);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_delay();
        test_beq();
        test_illegal();
        test_fetch_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
